// File: rtl/avmm_stream_pkg.sv
// Shared types and byte-lane helpers for the Avalon-MM word streamers.
package avmm_stream_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam int BYTES_PER_WORD = 4;

   // Emission order of byte lanes within a word: little-endian.
   localparam logic [1:0] LANE_ORDER [BYTES_PER_WORD] = '{2'd0, 2'd1, 2'd2, 2'd3};

   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[8*LANE_ORDER[idx] +: 8];
   endfunction

endpackage

// File: rtl/avmm_word_stream_reader_if.sv
// Memory-side Avalon-MM read signals plus the outgoing byte stream handshake.
interface avmm_word_stream_reader_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect;
   logic              avm_write;
   logic [3:0]        avm_byteenable;
   logic              avm_clken;
   logic [DATA_W-1:0] avm_readdata;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
      output out_data, out_valid,
      input  avm_readdata, out_ready
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
      input  out_data, out_valid,
      output avm_readdata, out_ready
   );
endinterface

// File: rtl/avmm_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count; pop_dat is valid while !empty.
// Zero-cycle read; caller guarantees no push when full and no pop when empty.
module avmm_sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   input  logic                       flush,
   output logic [W-1:0]               pop_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wptr_q] <= push_dat;
   end

   assign pop_dat = mem_q[rptr_q];
   assign count   = cnt_q;
   assign empty   = (cnt_q == '0);

endmodule

// File: rtl/avmm_word_stream_reader.sv
// Reads word_count words from a fixed-latency Avalon-MM slave and streams them out LSB byte first.
// Reads issue only while FIFO occupancy + in-flight < FIFO_DEPTH; out_valid/out_data hold while out_ready=0.
module avmm_word_stream_reader
   import avmm_stream_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   avmm_word_stream_reader_if.master bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CR_W  = $clog2(FIFO_DEPTH + RD_LATENCY) + 2;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W:0]       cnt_q, cnt_d, issue_q, issue_d;
   logic [RD_LATENCY-1:0] rvld_q, rvld_d;
   logic                  abort_q, abort_d;
   logic                  ser_busy_q, ser_busy_d;
   logic [1:0]            idx_q, idx_d;
   logic [DATA_W-1:0]     word_q, word_d;

   logic              rd_issue, active, abort_fire, flush, push, pop, hs, last_hs, fifo_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [DATA_W-1:0] fifo_dat;
   logic [CR_W-1:0]   infl, credit_used;

   assign active      = (state_q == RUN) || (state_q == DRAIN);
   assign abort_fire  = abort && active;
   assign flush       = abort_fire || abort_q;
   assign credit_used = CR_W'(fifo_cnt) + infl;

   always_comb begin
      infl = '0;
      for (int i = 0; i < RD_LATENCY; i++) infl = infl + CR_W'(rvld_q[i]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (word_count == '0) ? DONE : RUN;
         RUN:     if (abort || issue_q == cnt_q) state_d = DRAIN;
         DRAIN:   if (infl == '0 && fifo_empty && !ser_busy_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = active;
      done     = (state_q == DONE);
      rd_issue = (state_q == RUN) && !abort && (issue_q < cnt_q)
                 && (credit_used < CR_W'(FIFO_DEPTH));
   end

   always_comb begin
      base_d  = base_q;
      cnt_d   = cnt_q;
      issue_d = issue_q;
      abort_d = abort_q;
      if (state_q == IDLE && start) begin
         base_d  = base_addr;
         cnt_d   = word_count;
         issue_d = '0;
         abort_d = 1'b0;
      end
      if (rd_issue)           issue_d = issue_q + (ADDR_W+1)'(1);
      if (abort_fire)         abort_d = 1'b1;
      if (state_q == DONE)    abort_d = 1'b0;
      rvld_d    = rvld_q << 1;
      rvld_d[0] = rd_issue;
   end

   // A word is popped on the last byte handshake so consecutive words stream without a bubble.
   always_comb begin
      hs         = ser_busy_q && bus.out_ready;
      last_hs    = hs && (idx_q == 2'(BYTES_PER_WORD - 1));
      pop        = !flush && !fifo_empty && (!ser_busy_q || last_hs);
      push       = rvld_q[RD_LATENCY-1] && !flush;
      ser_busy_d = ser_busy_q;
      idx_d      = idx_q;
      word_d     = word_q;
      if (flush) begin
         ser_busy_d = 1'b0;
      end else if (pop) begin
         ser_busy_d = 1'b1;
         idx_d      = '0;
         word_d     = fifo_dat;
      end else if (last_hs) begin
         ser_busy_d = 1'b0;
      end else if (hs) begin
         idx_d = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q     <= '0;
         cnt_q      <= '0;
         issue_q    <= '0;
         rvld_q     <= '0;
         abort_q    <= 1'b0;
         ser_busy_q <= 1'b0;
         idx_q      <= '0;
         word_q     <= '0;
      end else begin
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         issue_q    <= issue_d;
         rvld_q     <= rvld_d;
         abort_q    <= abort_d;
         ser_busy_q <= ser_busy_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
      end
   end

   avmm_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .push_dat (bus.avm_readdata),
      .pop      (pop),
      .flush    (flush),
      .pop_dat  (fifo_dat),
      .count    (fifo_cnt),
      .empty    (fifo_empty)
   );

   assign bus.avm_address    = base_q + issue_q[ADDR_W-1:0];
   assign bus.avm_chipselect = rd_issue;
   assign bus.avm_write      = 1'b0;
   assign bus.avm_byteenable = 4'hF;
   assign bus.avm_clken      = 1'b1;
   assign bus.out_valid      = ser_busy_q;
   assign bus.out_data       = lane_byte(word_q, idx_q);

endmodule
